// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, a one-entry fetched
// instruction buffer, and branch redirect with kill of an in-flight response.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
   input  logic        stall_d,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid_f,
   output logic [31:0] instr_f,
   output logic [31:0] pc_f,
   output logic [31:0] pc_plus4_f,
   output logic        flush_d,
   output logic        flush_e
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10
   } state_t;

   state_t      state_r;
   logic [31:0] fetch_pc_r;
   logic [31:0] redir_pc_r;
   logic        redir_pend_r;
   logic        kill_r;
   logic        hold_r;
   logic        instr_valid_r;
   logic [31:0] instr_r;
   logic [31:0] pc_r;
   logic [31:0] pc_plus4_r;

   logic        req_valid_s;
   logic        hs_s;
   logic        rsp_s;
   logic [31:0] target_s;

   function automatic logic [31:0] next_word(input logic [31:0] addr);
      return addr + 32'd4;
   endfunction

   // Request qualification, handshake and response decode
   always_comb begin
      req_valid_s = 1'b0;
      target_s    = br_target_i & 32'hFFFF_FFFC;
      if (state_r == REQ) begin
         // hold_r keeps a presented request stable until it is accepted
         req_valid_s = hold_r | ~instr_valid_r | ~stall_d;
      end else begin
         req_valid_s = 1'b0;
      end
      hs_s  = req_valid_s & imem_req_ready;
      rsp_s = (state_r == WAIT) & imem_rsp_valid;
   end

   assign imem_req_valid = req_valid_s;
   assign imem_req_addr  = fetch_pc_r;
   assign instr_valid_f  = instr_valid_r;
   assign instr_f        = instr_r;
   assign pc_f           = pc_r;
   assign pc_plus4_f     = pc_plus4_r;
   assign flush_d        = br_taken_i;
   assign flush_e        = br_taken_i;

   // Fetch FSM: next fetch address, pending redirect and kill tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         fetch_pc_r   <= RESET_PC;
         redir_pc_r   <= RESET_PC;
         redir_pend_r <= 1'b0;
         kill_r       <= 1'b0;
         hold_r       <= 1'b0;
      end else begin
         hold_r <= req_valid_s & ~imem_req_ready;
         case (state_r)
            IDLE: begin
               state_r <= REQ;
               if (br_taken_i) begin
                  fetch_pc_r <= target_s;
               end
            end
            REQ: begin
               if (br_taken_i) begin
                  if (hs_s) begin
                     state_r      <= WAIT;
                     kill_r       <= 1'b1;
                     fetch_pc_r   <= target_s;
                     redir_pend_r <= 1'b0;
                  end else if (req_valid_s) begin
                     // pending request must not change: apply target after its handshake
                     kill_r       <= 1'b1;
                     redir_pend_r <= 1'b1;
                     redir_pc_r   <= target_s;
                  end else begin
                     fetch_pc_r <= target_s;
                  end
               end else if (hs_s) begin
                  state_r      <= WAIT;
                  redir_pend_r <= 1'b0;
                  fetch_pc_r   <= redir_pend_r ? redir_pc_r : next_word(fetch_pc_r);
               end
            end
            WAIT: begin
               if (br_taken_i) begin
                  fetch_pc_r <= target_s;
                  if (imem_rsp_valid) begin
                     kill_r  <= 1'b0;
                     state_r <= REQ;
                  end else begin
                     kill_r <= 1'b1;
                  end
               end else if (imem_rsp_valid) begin
                  kill_r  <= 1'b0;
                  state_r <= REQ;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Fetched instruction buffer: redirect flush beats refill beats drain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_valid_r <= 1'b0;
         instr_r       <= 32'h0000_0000;
         pc_r          <= 32'h0000_0000;
         pc_plus4_r    <= 32'h0000_0004;
      end else begin
         if (br_taken_i) begin
            instr_valid_r <= 1'b0;
         end else if (rsp_s && !kill_r) begin
            instr_valid_r <= 1'b1;
            instr_r       <= imem_rsp_data;
            pc_r          <= fetch_pc_r - 32'd4;
            pc_plus4_r    <= fetch_pc_r;
         end else if (instr_valid_r && !stall_d) begin
            instr_valid_r <= 1'b0;
         end
      end
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 br_taken_i  input  1  SHALL be the redirect request from the execute-stage branch-condition logic (branch taken, JAL, JALR).
REQ-005 br_target_i  input  32  SHALL be the redirect target address, sampled when br_taken_i=1.
REQ-006 stall_d  input  1  SHALL be the decode stall; 1 = decode does not consume the current instruction.
REQ-007 imem_req_valid  output  1  SHALL be the instruction-memory request valid.
REQ-008 imem_req_ready  input  1  SHALL be the instruction-memory request ready.
REQ-009 imem_req_addr  output  32  SHALL be the instruction-memory request address.
REQ-010 imem_rsp_valid  input  1  SHALL be the instruction-memory response valid, one cycle per accepted request, no backpressure.
REQ-011 imem_rsp_data  input  32  SHALL be the instruction-memory response data.
REQ-012 instr_valid_f  output  1  SHALL indicate that instr_f/pc_f hold a valid fetched instruction.
REQ-013 instr_f, pc_f, pc_plus4_f  output  32 each  SHALL be the buffered instruction, its address, and address+4.
REQ-014 flush_d, flush_e  output  1 each  SHALL be the flush strobes for the decode and execute pipeline registers.

Function
REQ-015 FSM states SHALL be IDLE, REQ and WAIT; fetch_pc register holds the next fetch address.
REQ-016 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-017 In REQ, imem_req_valid SHALL be 1 only when the buffer is empty or drained this cycle (instr_valid_f=1 and stall_d=0); imem_req_addr = fetch_pc.
REQ-018 Once imem_req_valid=1, valid and addr SHALL stay stable until imem_req_ready=1.
REQ-019 On handshake (valid & ready), fetch_pc SHALL become fetch_pc+4 (mod 2^32), and the FSM SHALL go to WAIT.
REQ-020 At most one request SHALL be outstanding.
REQ-021 In WAIT, on imem_rsp_valid=1, the FSM SHALL load imem_rsp_data and the request address into the buffer, set instr_valid_f=1, and return to REQ, unless kill=1.
REQ-022 The buffer SHALL hold its contents while stall_d=1. It SHALL clear (instr_valid_f=0) after the cycle it is consumed, unless it is refilled in that same cycle.
REQ-023 pc_plus4_f SHALL equal pc_f+4, wrapping modulo 2^32.
REQ-024 flush_d and flush_e SHALL equal br_taken_i combinationally.
REQ-025 On br_taken_i=1, the following SHALL happen:
- fetch_pc <= {br_target_i[31:2],2'b00};
- instr_valid_f <= 0;
- the FSM goes to REQ, unless a request is in flight.
REQ-026 A redirect with a request in flight SHALL set kill=1:
- in flight means WAIT without a response this cycle, or an REQ handshake this cycle;
- the FSM goes to (or stays in) WAIT;
- the next response is discarded, then kill clears and the FSM goes to REQ.
REQ-027 A redirect in REQ with imem_req_valid=1 and imem_req_ready=0 SHALL NOT change the pending request (REQ-018). The FSM SHALL set kill=1 and complete that request, and its response SHALL be discarded.
REQ-028 A redirect in WAIT in the same cycle as imem_rsp_valid=1 SHALL discard that response, leave kill=0 and go to REQ.
REQ-029 A redirect SHALL take priority over stall_d and over buffer refill.
REQ-030 fetch_pc after a redirect SHALL NOT be incremented by the handshake of a killed request.

Reset
REQ-031 While rst=1, the block SHALL hold these values:
- state=IDLE, fetch_pc=RESET_PC, kill=0;
- imem_req_valid=0, imem_req_addr=RESET_PC;
- instr_valid_f=0, instr_f=0, pc_f=0, pc_plus4_f=4.
REQ-032 Reset asserted mid-transaction SHALL abandon the outstanding request. A response arriving within the first two cycles after reset release SHALL be ignored.

Verification
REQ-033 Reset release, ready=1, 1-cycle response latency, stall_d=0 -> request addresses 0x0, 0x4, 0x8 in consecutive handshakes; pc_f follows the same sequence with matching instr_f.
REQ-034 stall_d=1 for 3 cycles with buffer valid -> instr_f/pc_f constant; imem_req_valid=0; fetch resumes at the next +4 address when stall_d=0.
REQ-035 br_taken_i=1, br_target_i=0x0000_0103 while in WAIT -> flush_d=flush_e=1 that cycle; pending response discarded; next request addr 0x0000_0100.
REQ-036 Redirect while req_valid=1, ready=0 at addr 0x10 -> addr stays 0x10 until ready; its response is dropped; next request 0x200 (target 0x200).
REQ-037 fetch_pc=0xFFFF_FFFC -> pc_plus4_f=0x0000_0000, next request addr 0x0000_0000.
REQ-038 rst pulsed while in WAIT -> outputs return to REQ-031 values immediately; first request after release at RESET_PC.
